uart_demux: RTL and testbench



---
 rtl/uart_link_pkg.sv | 36 +++
 rtl/uart_link_watchdog.sv | 43 ++++
 rtl/uart_demux.sv | 161 ++++++++++++++++
 tb/tb_uart_demux.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared definitions for the inter-board UART link (transmit-side mux and
// receive-side demux): sync keyword, word selectors, MATCH_CTRL bit layout,
// receive FSM state encoding and a small saturating-increment helper.
package uart_link_pkg;

    // High byte of the SYNC word; the full SYNC word is {LINK_KEYWORD, 8'h00}.
    localparam logic [7:0] LINK_KEYWORD = 8'h0F;

    // Word selectors carried in word[15:12].
    localparam logic [3:0] SEL_SYNC       = 4'd0;
    localparam logic [3:0] SEL_PL1_POSX   = 4'd1;
    localparam logic [3:0] SEL_PL1_POSY   = 4'd2;
    localparam logic [3:0] SEL_BALL_POSX  = 4'd5;
    localparam logic [3:0] SEL_BALL_POSY  = 4'd6;
    localparam logic [3:0] SEL_MATCH_CTRL = 4'd7;

    // MATCH_CTRL payload layout (bits 9:8 are unused).
    localparam int MC_END_GAME_BIT   = 11;
    localparam int MC_FLAG_POINT_BIT = 10;
    localparam int MC_PL2_SCORE_LSB  = 4;
    localparam int MC_PL1_SCORE_LSB  = 0;

    // Receive framing FSM.
    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_SYNC_LO = 2'd1,
        ST_HI      = 2'd2,
        ST_LO      = 2'd3
    } link_state_t;

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_link_watchdog.sv
// Link inactivity watchdog. The counter restarts on every kick and otherwise
// counts up, saturating at TIMEOUT_CYCLES. 'expired' is a one-cycle pulse on
// the cycle whose edge would bring the count to TIMEOUT_CYCLES; a kick in
// that same cycle wins and suppresses the pulse. 'clear' is a synchronous
// reset of the counter.
module uart_link_watchdog #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic clear,
    input  logic kick,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart on kick, otherwise count up until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (kick) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired = !clear && !kick && (cnt_q == LAST);

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_demux.sv
// Receive-side UART link demux: pairs bytes into 16-bit words (high byte
// first), locks onto the SYNC word, decodes the 16-word round into registered
// game-state outputs and reports link loss via an inactivity watchdog.
// Optional build macro UART_DEMUX_ERRCNT_EN adds the err_cnt lock-loss counter.
module uart_demux
    import uart_link_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] KEYWORD        = LINK_KEYWORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic [11:0] pl1_posx,
    output logic [11:0] pl1_posy,
    output logic [11:0] ball_posx,
    output logic [11:0] ball_posy,
    output logic [3:0]  pl1_score,
    output logic [3:0]  pl2_score,
    output logic        flag_point,
    output logic        end_game,
    output logic        con_broken,
    output logic        word_valid
`ifdef UART_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam logic [15:0] SYNC_WORD = {KEYWORD, 8'h00};

    link_state_t state_q;
    logic [3:0]  exp_sel_q;
    logic [7:0]  hi_byte_q;
    logic [11:0] pl1_posx_q, pl1_posy_q, ball_posx_q, ball_posy_q;
    logic [3:0]  pl1_score_q, pl2_score_q;
    logic        flag_point_q, end_game_q, con_broken_q, word_valid_q;

    logic        wd_expired;
    logic [15:0] word_w;
    logic        word_bad;

    uart_link_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .clear   (rst),
        .kick    (rx_done),
        .expired (wd_expired)
    );

    // Candidate word when the low byte arrives; a SYNC slot must be exact.
    assign word_w   = {hi_byte_q, rx_data};
    assign word_bad = (word_w[15:12] != exp_sel_q) ||
                      ((exp_sel_q == SEL_SYNC) && (word_w != SYNC_WORD));

    // Framing FSM with registered decode outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            exp_sel_q    <= SEL_SYNC;
            hi_byte_q    <= 8'h00;
            pl1_posx_q   <= '0;
            pl1_posy_q   <= '0;
            ball_posx_q  <= '0;
            ball_posy_q  <= '0;
            pl1_score_q  <= '0;
            pl2_score_q  <= '0;
            flag_point_q <= 1'b0;
            end_game_q   <= 1'b0;
            con_broken_q <= 1'b1;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (wd_expired) begin
                // Data outputs deliberately hold their last values.
                state_q      <= ST_HUNT;
                con_broken_q <= 1'b1;
            end else if (rx_done) begin
                unique case (state_q)
                    ST_HUNT: begin
                        if (rx_data == KEYWORD) state_q <= ST_SYNC_LO;
                    end
                    ST_SYNC_LO: begin
                        if (rx_data == 8'h00) begin
                            state_q      <= ST_HI;
                            exp_sel_q    <= SEL_PL1_POSX;
                            con_broken_q <= 1'b0;
                        end else if (rx_data != KEYWORD) begin
                            state_q <= ST_HUNT;
                        end
                    end
                    ST_HI: begin
                        hi_byte_q <= rx_data;
                        state_q   <= ST_LO;
                    end
                    ST_LO: begin
                        if (word_bad) begin
                            state_q <= ST_HUNT;
                        end else begin
                            // A good SYNC slot is a resync: 0 -> 1, no pulse.
                            state_q   <= ST_HI;
                            exp_sel_q <= exp_sel_q + 4'd1;
                            if (exp_sel_q != SEL_SYNC) begin
                                word_valid_q <= 1'b1;
                                case (exp_sel_q)
                                    SEL_PL1_POSX:  pl1_posx_q  <= word_w[11:0];
                                    SEL_PL1_POSY:  pl1_posy_q  <= word_w[11:0];
                                    SEL_BALL_POSX: ball_posx_q <= word_w[11:0];
                                    SEL_BALL_POSY: ball_posy_q <= word_w[11:0];
                                    SEL_MATCH_CTRL: begin
                                        end_game_q   <= word_w[MC_END_GAME_BIT];
                                        flag_point_q <= word_w[MC_FLAG_POINT_BIT];
                                        pl2_score_q  <= word_w[MC_PL2_SCORE_LSB +: 4];
                                        pl1_score_q  <= word_w[MC_PL1_SCORE_LSB +: 4];
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                    default: state_q <= ST_HUNT;
                endcase
            end
        end
    end

`ifdef UART_DEMUX_ERRCNT_EN
    logic       locked_w;
    logic       lock_lost_w;
    logic [7:0] err_cnt_q;

    assign locked_w    = (state_q == ST_HI) || (state_q == ST_LO);
    assign lock_lost_w = (wd_expired && locked_w) ||
                         (!wd_expired && rx_done && (state_q == ST_LO) && word_bad);

    // Saturating count of lock losses while framed.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else if (lock_lost_w) begin
            err_cnt_q <= sat_inc8(err_cnt_q);
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign pl1_posx   = pl1_posx_q;
    assign pl1_posy   = pl1_posy_q;
    assign ball_posx  = ball_posx_q;
    assign ball_posy  = ball_posy_q;
    assign pl1_score  = pl1_score_q;
    assign pl2_score  = pl2_score_q;
    assign flag_point = flag_point_q;
    assign end_game   = end_game_q;
    assign con_broken = con_broken_q;
    assign word_valid = word_valid_q;

endmodule

// File: tb/tb_uart_demux.sv
// Self-checking bench for uart_demux: a decode table for the lock-and-decode
// round, hand-written corner sequences (resync, mismatch, round wrap,
// watchdog edge, reset mid-word) and a randomized phase compared against a
// byte-stream reference model.
module tb_uart_demux;

    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
    logic [3:0]  pl1_score, pl2_score;
    logic        flag_point, end_game, con_broken, word_valid;
`ifdef UART_DEMUX_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    uart_demux #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .pl1_posx   (pl1_posx),
        .pl1_posy   (pl1_posy),
        .ball_posx  (ball_posx),
        .ball_posy  (ball_posy),
        .pl1_score  (pl1_score),
        .pl2_score  (pl2_score),
        .flag_point (flag_point),
        .end_game   (end_game),
        .con_broken (con_broken),
        .word_valid (word_valid)
`ifdef UART_DEMUX_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wv_cnt = 0;

    always @(negedge clk) if (word_valid === 1'b1) wv_cnt++;

    // ---------------- reference model (byte-stream level) ----------------
    logic [11:0] m_p1x, m_p1y, m_bx, m_by;
    logic [3:0]  m_s1, m_s2;
    logic        m_fp, m_eg, m_cb, m_wv;
    int          m_err, m_next;
    bit          m_locked, m_saw_kw;
    logic [7:0]  m_part[$];

    function automatic logic [57:0] pack(input logic [11:0] p1x, p1y, bx, by,
                                         input logic [3:0] s1, s2,
                                         input logic fp, eg);
        return {p1x, p1y, bx, by, s1, s2, fp, eg};
    endfunction

    function automatic logic [57:0] dut_out();
        return pack(pl1_posx, pl1_posy, ball_posx, ball_posy,
                    pl1_score, pl2_score, flag_point, end_game);
    endfunction

    function automatic logic [57:0] m_out();
        return pack(m_p1x, m_p1y, m_bx, m_by, m_s1, m_s2, m_fp, m_eg);
    endfunction

    task automatic model_reset();
        {m_p1x, m_p1y, m_bx, m_by} = '0;
        {m_s1, m_s2, m_fp, m_eg}   = '0;
        m_cb = 1'b1; m_wv = 1'b0; m_err = 0; m_next = 0;
        m_locked = 0; m_saw_kw = 0; m_part.delete();
    endtask

    task automatic model_lose();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_timeout();
        if (m_locked) model_lose();
        m_locked = 0; m_saw_kw = 0; m_part.delete(); m_cb = 1'b1; m_wv = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [15:0] w;
        m_wv = 1'b0;
        if (!m_locked) begin
            if (m_saw_kw && b == 8'h00) begin
                m_locked = 1; m_saw_kw = 0; m_next = 1; m_cb = 1'b0; m_part.delete();
            end else begin
                m_saw_kw = (b == 8'h0F);
            end
        end else if (m_part.size() == 0) begin
            m_part.push_back(b);
        end else begin
            w = {m_part[0], b};
            m_part.delete();
            if (int'(w[15:12]) != m_next || (m_next == 0 && w != 16'h0F00)) begin
                m_locked = 0; m_saw_kw = 0; model_lose();
            end else begin
                if (m_next != 0) begin
                    m_wv = 1'b1;
                    case (m_next)
                        1: m_p1x = w[11:0];
                        2: m_p1y = w[11:0];
                        5: m_bx  = w[11:0];
                        6: m_by  = w[11:0];
                        7: begin m_eg = w[11]; m_fp = w[10]; m_s2 = w[7:4]; m_s1 = w[3:0]; end
                        default: ;
                    endcase
                end
                m_next = (m_next + 1) % 16;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_out"}, 64'(dut_out()), 64'(m_out()));
        chk({tag, "_cb"}, 64'(con_broken), 64'(m_cb));
        chk({tag, "_wv"}, 64'(word_valid), 64'(m_wv));
`ifdef UART_DEMUX_ERRCNT_EN
        chk({tag, "_err"}, 64'(err_cnt), 64'(m_err));
`endif
    endtask

    // Called at a negedge; strobes one byte and returns at the next negedge,
    // where the outputs already reflect that byte.
    task automatic send(input logic [7:0] b);
        model_byte(b);
        rx_data = b; rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        $display("tx byte=%02h cb=%0d wv=%0d p1x=%03h p1y=%03h bx=%03h by=%03h",
                 b, con_broken, word_valid, pl1_posx, pl1_posy, ball_posx, ball_posy);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        if (n >= TO) model_timeout();
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        send(w[15:8]); idle(gap); send(w[7:0]); idle(gap);
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic sync();
        send(8'h0F); send(8'h00);
    endtask

    typedef struct {
        logic [15:0] word;
        logic        exp_wv;
        logic [57:0] exp_out;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int base;
        logic [57:0] prev, fin;
        logic [3:0] s;
        int r;

        fin = pack(12'h123, 12'h456, 12'h789, 12'hABC, 4'd3, 4'd5, 1'b1, 1'b1);
        tbl[0]  = '{16'h1123, 1'b1, pack(12'h123, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{16'h2456, 1'b1, pack(12'h123, 12'h456, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{16'h3ABC, 1'b1, pack(12'h123, 12'h456, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{16'h4DEF, 1'b1, pack(12'h123, 12'h456, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{16'h5789, 1'b1, pack(12'h123, 12'h456, 12'h789, 0, 0, 0, 0, 0)};
        tbl[5]  = '{16'h6ABC, 1'b1, pack(12'h123, 12'h456, 12'h789, 12'hABC, 0, 0, 0, 0)};
        tbl[6]  = '{16'h7C53, 1'b1, fin};
        tbl[7]  = '{16'h8123, 1'b1, fin};
        tbl[8]  = '{16'h9456, 1'b1, fin};
        tbl[9]  = '{16'hA789, 1'b1, fin};
        tbl[10] = '{16'hBABC, 1'b1, fin};
        tbl[11] = '{16'hCDEF, 1'b1, fin};
        tbl[12] = '{16'hD0F0, 1'b1, fin};
        tbl[13] = '{16'hE00F, 1'b1, fin};
        tbl[14] = '{16'hF000, 1'b1, fin};

        // Reset state
        do_reset();
        chk("rst_out", 64'(dut_out()), 64'd0);
        chk("rst_cb", 64'(con_broken), 64'd1);
        chk("rst_wv", 64'(word_valid), 64'd0);
`ifdef UART_DEMUX_ERRCNT_EN
        chk("rst_err", 64'(err_cnt), 64'd0);
`endif

        // Lock and decode, table-driven
        base = wv_cnt;
        send(8'h0F);
        chk("lock_cb_kw", 64'(con_broken), 64'd1);
        send(8'h00);
        chk("lock_cb_00", 64'(con_broken), 64'd0);
        prev = '0;
        for (int i = 0; i < 15; i++) begin
            send(tbl[i].word[15:8]);
            chk($sformatf("tbl%0d_hi_wv", i), 64'(word_valid), 64'd0);
            chk($sformatf("tbl%0d_hi_out", i), 64'(dut_out()), 64'(prev));
            send(tbl[i].word[7:0]);
            chk($sformatf("tbl%0d_wv", i), 64'(word_valid), 64'(tbl[i].exp_wv));
            chk($sformatf("tbl%0d_out", i), 64'(dut_out()), 64'(tbl[i].exp_out));
            prev = tbl[i].exp_out;
            idle(1);
            chk($sformatf("tbl%0d_wv_drop", i), 64'(word_valid), 64'd0);
        end
        chk("lock_wv_count", 64'(wv_cnt - base), 64'd15);

        // Garbage then sync
        do_reset();
        send(8'h55); send(8'h0F); send(8'h0F); send(8'h00);
        chk("garb_cb", 64'(con_broken), 64'd0);
        send_word(16'h1ABC, 1);
        chk("garb_p1x", 64'(pl1_posx), 64'hABC);

        // Selector mismatch while expecting sel 2
        do_reset();
        sync();
        send_word(16'h1111, 0);
        send_word(16'h5111, 0);
        chk("mis_bx", 64'(ball_posx), 64'd0);
        chk("mis_cb", 64'(con_broken), 64'd0);
`ifdef UART_DEMUX_ERRCNT_EN
        chk("mis_err", 64'(err_cnt), 64'd1);
`endif
        base = wv_cnt;
        send_word(16'h2222, 0);
        chk("mis_p1y", 64'(pl1_posy), 64'd0);
        chk("mis_nowv", 64'(wv_cnt - base), 64'd0);

        // Round wrap: resync accepted, bad resync drops lock
        do_reset();
        sync();
        for (int i = 1; i < 16; i++) send_word({4'(i), 12'h000}, 0);
        send_word(16'h0F00, 0);
        send_word(16'h1001, 0);
        chk("wrap_p1x", 64'(pl1_posx), 64'h001);
        chk("wrap_cb", 64'(con_broken), 64'd0);
        for (int i = 2; i < 16; i++) send_word({4'(i), 12'h000}, 0);
        send_word(16'h0F01, 0);
        send_word(16'h1777, 0);
        chk("wrap_bad_p1x", 64'(pl1_posx), 64'h001);
`ifdef UART_DEMUX_ERRCNT_EN
        chk("wrap_bad_err", 64'(err_cnt), 64'd1);
`endif

        // Watchdog expiry, outputs hold
        do_reset();
        sync();
        send_word(16'h1111, 0);
        repeat (TO - 1) @(negedge clk);
        chk("wd_pre_cb", 64'(con_broken), 64'd0);
        @(negedge clk);
        chk("wd_exp_cb", 64'(con_broken), 64'd1);
        chk("wd_hold", 64'(pl1_posx), 64'h111);
        model_timeout();
`ifdef UART_DEMUX_ERRCNT_EN
        chk("wd_err", 64'(err_cnt), 64'd1);
`endif
        send_word(16'h1999, 0);
        chk("wd_hunt_p1x", 64'(pl1_posx), 64'h111);

        // Watchdog: rx_done on the expiry cycle wins
        sync();
        send_word(16'h1222, 0);
        repeat (TO - 1) @(negedge clk);
        send(8'h23);
        chk("wd_kick_cb", 64'(con_broken), 64'd0);
        idle(5);
        send(8'h45);
        chk("wd_kick_p1y", 64'(pl1_posy), 64'h345);
        chk("wd_kick_cb2", 64'(con_broken), 64'd0);

        // Reset mid-word
        sync();
        send(8'h15);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rstmid_out", 64'(dut_out()), 64'd0);
        chk("rstmid_cb", 64'(con_broken), 64'd1);
        send(8'h55);
        chk("rstmid_lo_out", 64'(dut_out()), 64'd0);
        chk("rstmid_lo_wv", 64'(word_valid), 64'd0);

        // Randomized stream against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8 || (r < 60 && !m_locked)) begin
                send(8'h0F); check_model("rnd_s0");
                idle($urandom_range(0, 2));
                send(8'h00); check_model("rnd_s1");
            end else if (r < 60) begin
                s = 4'(m_next);
                if (s == 4'd0) send(8'h0F); else send({s, 4'($urandom)});
                check_model("rnd_hi");
                idle($urandom_range(0, 2));
                if (s == 4'd0) send(8'h00); else send(8'($urandom));
                check_model("rnd_lo");
            end else if (r < 70) begin
                send(8'($urandom)); check_model("rnd_whi");
                send(8'($urandom)); check_model("rnd_wlo");
            end else if (r < 72) begin
                idle(TO + 10); check_model("rnd_idle");
            end else begin
                send(8'($urandom)); check_model("rnd_byte");
            end
            idle($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
